// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline-stage register with a 1-entry skid buffer and flush-to-bubble.
// Optional statistics counters are built only when PIPE_STAGE_STAT_EN is defined.
module pipe_stage_skid #(
  parameter int unsigned DATA_W = 160,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  kill_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   main_q;
  logic [DATA_W-1:0]   skid_q;
  logic                out_valid_q;
  logic                in_ready_q;

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  // NOTE: payload registers are reset too, because an invalid slot must read as an all-zero NOP.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_q      <= in_data;
            out_valid_q <= 1'b1;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (in_fire) begin
            skid_q     <= in_data;
            in_ready_q <= 1'b0;
            state_q    <= FULL;
          end else if (out_fire) begin
            main_q      <= '0;
            out_valid_q <= 1'b0;
            state_q     <= EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain path can move.
          if (out_fire) begin
            main_q     <= skid_q;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
            state_q    <= BUSY;
          end
        end
        default: begin
          state_q     <= EMPTY;
          main_q      <= '0;
          skid_q      <= '0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

`ifdef PIPE_STAGE_STAT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] kill_cnt_q,  kill_cnt_d;
  logic             stall_evt;
  logic             kill_evt;

  assign stall_evt = out_valid_q & ~out_ready & ~flush;
  // The skid holds a beat exactly when in_ready is low.
  assign kill_evt  = flush & (out_valid_q | ~in_ready_q);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    kill_cnt_d  = kill_cnt_q;
    if (stall_evt && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (kill_evt  && (kill_cnt_q  != '1)) kill_cnt_d  = kill_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      kill_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      kill_cnt_q  <= kill_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign kill_cnt  = kill_cnt_q;
`else
  assign stall_cnt = '0;
  assign kill_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: a queue model of held beats acts as scoreboard;
// directed handshake/flush/reset scenarios are followed by a long random run.
module tb_pipe_stage_skid;

  localparam int unsigned DATA_W = 160;
  localparam int unsigned CNT_W  = 32;
`ifdef PIPE_STAGE_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  kill_cnt;

  pipe_stage_skid #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt),
    .kill_cnt  (kill_cnt)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int errors = 0;

  // Reference: beats currently held by the stage, oldest first (at most two).
  logic [DATA_W-1:0] mq[$];
  logic [CNT_W-1:0]  stall_m = '0;
  logic [CNT_W-1:0]  kill_m  = '0;

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock: drive inputs, compare outputs against the model at negedge, advance the model.
  task automatic cycle(input logic iv, input logic [DATA_W-1:0] id, input logic ordy,
                       input logic fl, input logic rst);
    logic exp_valid, exp_ready, in_fire_m, out_fire_m;
    logic [DATA_W-1:0] exp_data;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    @(negedge clk);
    exp_valid = (mq.size() > 0);
    exp_ready = (mq.size() < 2);
    exp_data  = exp_valid ? mq[0] : '0;
    check("out_valid", out_valid, exp_valid);
    check("in_ready",  in_ready,  exp_ready);
    check("out_data",  out_data,  exp_data);
    check("stall_cnt", stall_cnt, STAT ? stall_m : '0);
    check("kill_cnt",  kill_cnt,  STAT ? kill_m  : '0);
    in_fire_m  = iv & exp_ready;
    out_fire_m = exp_valid & ordy;
    if (rst) begin
      mq.delete();
      stall_m = '0;
      kill_m  = '0;
    end else begin
      if (exp_valid && !ordy && !fl && stall_m != '1) stall_m++;
      if (fl && exp_valid && kill_m != '1) kill_m++;
      if (out_fire_m) void'(mq.pop_front());
      if (fl) mq.delete();
      else if (in_fire_m) mq.push_back(id);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [DATA_W-1:0] held;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0; reset = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // 1: streaming 1,2,3.. at full throughput.
    for (int i = 1; i <= 8; i++) cycle(1'b1, DATA_W'(i), 1'b1, 1'b0, 1'b0);
    check("t1_last_data", out_data, DATA_W'(8));
    for (int i = 0; i < 2; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // 2: backpressure into FULL, C held off, then drain A, B, C in order.
    do_reset();
    cycle(1'b1, DATA_W'('hA), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, DATA_W'('hB), 1'b0, 1'b0, 1'b0);
    check("t2_full_in_ready", in_ready, '0);
    cycle(1'b1, DATA_W'('hC), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, DATA_W'('hC), 1'b1, 1'b0, 1'b0);
    check("t2_second_beat", out_data, DATA_W'('hB));
    cycle(1'b1, DATA_W'('hC), 1'b1, 1'b0, 1'b0);
    check("t2_third_beat", out_data, DATA_W'('hC));
    for (int i = 0; i < 2; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // 3: flush while FULL with D offered; D must never appear.
    do_reset();
    cycle(1'b1, DATA_W'('h11), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, DATA_W'('h22), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, DATA_W'('hDD), 1'b0, 1'b1, 1'b0);
    check("t3_bubble_valid", out_valid, '0);
    check("t3_bubble_data",  out_data,  '0);
    check("t3_kill", kill_cnt, STAT ? DATA_W'(1) : '0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // 4: five stalled cycles with a held beat.
    do_reset();
    cycle(1'b1, DATA_W'('h5A5A), 1'b0, 1'b0, 1'b0);
    held = DATA_W'('h5A5A);
    for (int i = 0; i < 5; i++) begin
      check("t4_stable", out_data, held);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    end
    check("t4_stall", stall_cnt, STAT ? DATA_W'(5) : '0);

    // 5: reset while FULL.
    cycle(1'b1, DATA_W'('h77), 1'b0, 1'b0, 1'b0);
    check("t5_full", in_ready, '0);
    do_reset();
    check("t5_valid", out_valid, '0);
    check("t5_data",  out_data,  '0);
    check("t5_ready", in_ready,  1'b1);
    check("t5_stall", stall_cnt, '0);

    // 6: random traffic with occasional flushes.
    for (int i = 0; i < 10000; i++)
      cycle(1'($urandom_range(0, 1)), rand_data(), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 31) == 0), 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
